// File: rtl/midi_rx_param.sv
// Parametrised MIDI serial receiver: LSB-first async line -> parallel word with valid/ready hold register.
// Latency: valid rises (DATA_BITS+STOP_BITS)*CLKS_PER_BIT + CLKS_PER_BIT/2 + 3 cycles after the start edge is seen.
// Backpressure: one-word hold register; a good word arriving while it is still occupied is dropped and overrun pulses.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   din        asynchronous serial input, idle high
//   dout       received word (LSB = first data bit), valid while 'valid' is high
//   valid      dout holds an unconsumed word
//   ready      consumer accepts dout when valid & ready
//   frame_err  one-cycle pulse when a stop bit decides low
//   overrun    one-cycle pulse when a good word is dropped
//   busy       receiver is inside a frame (any state other than IDLE)
module midi_rx_param #(
  parameter int CLKS_PER_BIT = 1600,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS);
  localparam int H  = CLKS_PER_BIT / 2;

  localparam logic [PW-1:0] PH_PRE = PW'(H - 1);
  localparam logic [PW-1:0] PH_MID = PW'(H);
  localparam logic [PW-1:0] PH_DEC = PW'(H + 1);
  localparam logic [PW-1:0] PH_END = PW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  // Input synchroniser; resets to the idle (high) line level.
  logic [SYNC_STAGES-1:0] sync;
  logic                   din_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= '1;
    else        sync <= {sync[SYNC_STAGES-2:0], din};
  end

  assign din_s = sync[SYNC_STAGES-1];

  state_t               state;
  logic [PW-1:0]        phase;
  logic [CW-1:0]        bit_cnt;   // data bit index in DATA, stop bit index in STOP
  logic [DATA_BITS-1:0] shreg;
  logic                 s_pre;     // sample taken at phase H-1
  logic                 s_mid;     // sample taken at phase H
  logic                 maj;
  logic                 at_dec;
  logic                 at_end;

  // Third vote is the live sample at phase H+1.
  assign maj    = (s_pre & s_mid) | (s_pre & din_s) | (s_mid & din_s);
  assign at_dec = (phase == PH_DEC);
  assign at_end = (phase == PH_END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      phase     <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      s_pre     <= 1'b1;
      s_mid     <= 1'b1;
      dout      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Consumption; a delivery in the same cycle overrides this below.
      if (valid && ready) valid <= 1'b0;

      if (state == IDLE || state == BRK) phase <= '0;
      else                               phase <= at_end ? '0 : phase + 1'b1;

      if (phase == PH_PRE) s_pre <= din_s;
      if (phase == PH_MID) s_mid <= din_s;

      case (state)
        IDLE: begin
          if (!din_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (at_dec && maj) begin
            // Start bit did not hold low through mid-bit: treat as noise.
            state <= IDLE;
            busy  <= 1'b0;
            phase <= '0;
          end else if (at_end) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end

        DATA: begin
          if (at_dec) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (at_end) begin
            if (bit_cnt == LAST_DATA) begin
              state   <= STOP;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        STOP: begin
          if (at_dec) begin
            if (!maj) begin
              frame_err <= 1'b1;
              state     <= BRK;
            end else if (bit_cnt == LAST_STOP) begin
              // Leave at mid-bit so a following start edge is caught on time.
              if (!valid || ready) begin
                dout  <= shreg;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state <= IDLE;
              busy  <= 1'b0;
              phase <= '0;
            end
          end else if (at_end) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        BRK: begin
          // A line held low reports one frame error, then waits here for idle.
          if (din_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_rx_param.sv
// Self-checking bench for midi_rx_param: three instances (fast 8N1, fast 7-bit/2-stop, default timing).
// Stimulus drives the serial pin bit by bit; a frame-level model predicts words, errors and overruns.
// Latency is measured from the busy rise (cycle E+1) to the valid / frame_err / overrun pulse.
module tb_midi_rx_param;

  localparam int CA = 16;   localparam int DA = 8; localparam int SA = 1; localparam int YA = 2;
  localparam int CB = 16;   localparam int DB = 7; localparam int SB = 2; localparam int YB = 3;
  localparam int CC = 1600; localparam int DC = 8; localparam int SC = 1; localparam int YC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_n;
  logic [2:0] din;
  logic [2:0] ready;
  wire  [2:0] valid_w, busy_w, ferr_w, ovr_w;
  wire  [7:0] dout_a, dout_c;
  wire  [6:0] dout_b;

  midi_rx_param #(.CLKS_PER_BIT(CA), .DATA_BITS(DA), .STOP_BITS(SA), .SYNC_STAGES(YA)) u_a (
    .clk(clk), .reset(rst_n[0]), .din(din[0]), .dout(dout_a), .valid(valid_w[0]),
    .ready(ready[0]), .frame_err(ferr_w[0]), .overrun(ovr_w[0]), .busy(busy_w[0]));

  midi_rx_param #(.CLKS_PER_BIT(CB), .DATA_BITS(DB), .STOP_BITS(SB), .SYNC_STAGES(YB)) u_b (
    .clk(clk), .reset(rst_n[1]), .din(din[1]), .dout(dout_b), .valid(valid_w[1]),
    .ready(ready[1]), .frame_err(ferr_w[1]), .overrun(ovr_w[1]), .busy(busy_w[1]));

  midi_rx_param #(.CLKS_PER_BIT(CC), .DATA_BITS(DC), .STOP_BITS(SC), .SYNC_STAGES(YC)) u_c (
    .clk(clk), .reset(rst_n[2]), .din(din[2]), .dout(dout_c), .valid(valid_w[2]),
    .ready(ready[2]), .frame_err(ferr_w[2]), .overrun(ovr_w[2]), .busy(busy_w[2]));

  int npass = 0;
  int nchk  = 0;

  function automatic logic [31:0] dout_of(input int d);
    case (d)
      0:       dout_of = {24'b0, dout_a};
      1:       dout_of = {25'b0, dout_b};
      default: dout_of = {24'b0, dout_c};
    endcase
  endfunction

  // ---------------- event monitor (samples on the falling edge) ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nval[3], nfe[3], nov[3];
  int t_brise[3], t_vrise[3], t_vfall[3], t_fe[3], t_ov[3];
  logic [31:0] vlog[3][32];
  logic [2:0] pv = '0;
  logic [2:0] pb = '0;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (busy_w[i] && !pb[i]) t_brise[i] = cyc;
      if (valid_w[i] && !pv[i]) begin
        if (nval[i] < 32) vlog[i][nval[i]] = dout_of(i);
        nval[i]++;
        t_vrise[i] = cyc;
      end
      if (!valid_w[i] && pv[i]) t_vfall[i] = cyc;
      if (ferr_w[i]) begin nfe[i]++; t_fe[i] = cyc; end
      if (ovr_w[i])  begin nov[i]++; t_ov[i] = cyc; end
    end
    pv = valid_w;
    pb = busy_w;
  end

  // ---------------- frame-level reference model ----------------
  int   exp_val[3], exp_fe[3], exp_ov[3], chk_idx[3];
  int   expw[3][32];
  logic m_full[3];

  function automatic int nd_of(input int d); return (d == 1) ? DB : 8; endfunction
  function automatic int ns_of(input int d); return (d == 1) ? SB : 1; endfunction
  function automatic int cpb_of(input int d); return (d == 2) ? CC : CA; endfunction

  // Cycles from busy rise (E+1) to the pulse decided at bit k (k=0 is the start bit).
  function automatic int lat(input int k, input int cpb);
    return k * cpb + cpb / 2 + 2;
  endfunction

  task automatic model_frame(input int d, input int data, input int stops);
    int w;
    w = data & ((1 << nd_of(d)) - 1);
    if (stops != (1 << ns_of(d)) - 1) begin
      exp_fe[d]++;
    end else if (!m_full[d] || ready[d]) begin
      if (exp_val[d] < 32) expw[d][exp_val[d]] = w;
      exp_val[d]++;
      m_full[d] = !ready[d];
    end else begin
      exp_ov[d]++;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_counts(input int d, input string tag);
    check({tag, "_nvalid"}, nval[d], exp_val[d]);
    check({tag, "_nferr"}, nfe[d], exp_fe[d]);
    check({tag, "_novr"}, nov[d], exp_ov[d]);
    for (int k = chk_idx[d]; k < nval[d] && k < exp_val[d] && k < 32; k++)
      check({tag, "_word"}, vlog[d][k], expw[d][k]);
    chk_idx[d] = nval[d];
  endtask

  task automatic wait_idle(input int d, input string tag);
    int n;
    n = 0;
    while (busy_w[d] && n < 4 * cpb_of(d)) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, busy_w[d], 1'b0);
  endtask

  // Drives one frame on the pin; noise flips one cycle near mid-bit of every bit.
  task automatic frame(input int d, input int data, input int stops, input bit noise);
    int nd, ns, cpb, v;
    nd = nd_of(d); ns = ns_of(d); cpb = cpb_of(d);
    model_frame(d, data, stops);
    for (int b = 0; b < 1 + nd + ns; b++) begin
      if (b == 0)       v = 0;
      else if (b <= nd) v = (data >> (b - 1)) & 1;
      else              v = (stops >> (b - 1 - nd)) & 1;
      for (int p = 0; p < cpb; p++) begin
        din[d] = (noise && p == cpb / 2 + 1) ? ~v[0] : v[0];
        tick();
      end
    end
    din[d] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int r;
    for (int d = 0; d < 3; d++) m_full[d] = 1'b0;
    rst_n = '0; din = '1; ready = '1;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      check("rst_valid", valid_w[d], 1'b0);
      check("rst_busy", busy_w[d], 1'b0);
      check("rst_dout", dout_of(d), 0);
      check("rst_ferr", ferr_w[d], 1'b0);
      check("rst_ovr", ovr_w[d], 1'b0);
    end
    rst_n = '1;
    repeat (4) tick();

    // Default timing: 0x90, valid at E+15203, dropped one cycle after handshake.
    frame(2, 'h90, 1, 1'b0);
    repeat (4) tick();
    check("c_latency", t_vrise[2] - t_brise[2], lat(DC + SC, CC));
    check("c_vwidth", t_vfall[2] - t_vrise[2], 1);
    check_counts(2, "c_single");

    // Back-to-back with no idle gap: fixed words then random ones.
    frame(0, 'h90, 1, 1'b0);
    frame(0, 'h3C, 1, 1'b0);
    frame(0, 'h7F, 1, 1'b0);
    for (int i = 0; i < 3; i++) frame(0, $urandom_range(0, 255), 1, 1'b0);
    wait_idle(0, "a_b2b");
    check("a_b2b_latency", t_vrise[0] - t_brise[0], lat(DA + SA, CA));
    check_counts(0, "a_b2b");

    // Start glitch: short low pulse must not produce a word.
    din[0] = 1'b0;
    repeat (3) tick();
    din[0] = 1'b1;
    repeat (2) tick();
    check("glitch_busy_start", busy_w[0], 1'b1);
    repeat (2 * CA) tick();
    check("glitch_busy_end", busy_w[0], 1'b0);
    check_counts(0, "glitch");
    frame(0, 'h45, 1, 1'b0);
    wait_idle(0, "post_glitch");
    check_counts(0, "post_glitch");

    // Framing error followed by a held-low line: one frame_err only.
    frame(0, 'hA5, 0, 1'b0);
    din[0] = 1'b0;
    repeat (5 * CA) tick();
    check("brk_busy", busy_w[0], 1'b1);
    check("ferr_latency", t_fe[0] - t_brise[0], lat(DA + SA, CA));
    check_counts(0, "break");
    din[0] = 1'b1;
    repeat (4) tick();
    wait_idle(0, "brk_exit");
    repeat (CA) tick();
    frame(0, 'h12, 1, 1'b0);
    wait_idle(0, "post_brk");
    check_counts(0, "post_brk");

    // Overrun: hold register occupied by 0x11 when 0x22 arrives.
    ready[0] = 1'b0;
    frame(0, 'h11, 1, 1'b0);
    frame(0, 'h22, 1, 1'b0);
    repeat (4) tick();
    check("ovr_dout", dout_a, 8'h11);
    check("ovr_valid", valid_w[0], 1'b1);
    check("ovr_latency", t_ov[0] - t_brise[0], lat(DA + SA, CA));
    check_counts(0, "overrun");
    ready[0] = 1'b1;
    m_full[0] = 1'b0;
    tick();
    check("ovr_drain_valid", valid_w[0], 1'b0);
    check("ovr_drain_dout", dout_a, 8'h11);

    // 7 data bits, 2 stop bits.
    frame(1, 'h5A, 3, 1'b0);
    wait_idle(1, "b_good");
    check("b_latency", t_vrise[1] - t_brise[1], lat(DB + SB, CB));
    check_counts(1, "b_good");
    frame(1, 'h33, 1, 1'b0);          // second stop bit low
    wait_idle(1, "b_stop2");
    check("b_stop2_latency", t_fe[1] - t_brise[1], lat(DB + SB, CB));
    check_counts(1, "b_stop2");
    frame(1, 'h2B, 2, 1'b0);          // first stop bit low
    wait_idle(1, "b_stop1");
    check("b_stop1_latency", t_fe[1] - t_brise[1], lat(DB + 1, CB));
    check_counts(1, "b_stop1");

    // Random words with single-cycle mid-bit noise on both fast instances.
    for (int i = 0; i < 4; i++) frame(1, $urandom_range(0, 127), 3, 1'b1);
    wait_idle(1, "b_noise");
    check_counts(1, "b_noise");
    for (int i = 0; i < 4; i++) frame(0, $urandom_range(0, 255), 1, 1'b1);
    wait_idle(0, "a_noise");
    check_counts(0, "a_noise");

    // Reset in the middle of DATA with a word held in the output register.
    ready[0] = 1'b0;
    frame(0, 'h6E, 1, 1'b0);
    wait_idle(0, "pre_rst");
    check_counts(0, "pre_rst");
    din[0] = 1'b0;
    repeat (CA) tick();
    for (int b = 0; b < 3; b++) begin
      r = $urandom_range(0, 1);
      din[0] = r[0];
      repeat (CA) tick();
    end
    rst_n[0] = 1'b0;
    #1;
    check("mid_rst_dout", dout_a, 8'h00);
    check("mid_rst_valid", valid_w[0], 1'b0);
    check("mid_rst_busy", busy_w[0], 1'b0);
    check("mid_rst_ferr", ferr_w[0], 1'b0);
    check("mid_rst_ovr", ovr_w[0], 1'b0);
    m_full[0] = 1'b0;
    din[0] = 1'b1;
    repeat (3) tick();
    rst_n[0] = 1'b1;
    ready[0] = 1'b1;
    repeat (2 * CA) tick();
    frame(0, $urandom_range(0, 255), 1, 1'b1);
    wait_idle(0, "post_rst");
    check_counts(0, "post_rst");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
